// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if -- bus bundle between the pipeline, mem_stage_ctrl and the LSU.
//
// Signals (named from the controller's point of view):
//   req_*  : upstream request handshake and fields (valid/ready, we, addr, wdata, dtype, rd)
//   lsu_*  : downstream load/store unit drive (addr, data, we, dtype) and returned data
//   rsp_*  : writeback response handshake and fields (valid/ready, data, rd, is_load, err)
// Modports:
//   master : environment side (drives requests, lsu_data_i and rsp_ready_i)
//   slave  : controller side (mem_stage_ctrl)
interface mem_stage_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [2:0]            req_dtype_i;
    logic [4:0]            req_rd_i;

    logic [ADDR_WIDTH-1:0] lsu_addr_o;
    logic [DATA_WIDTH-1:0] lsu_data_o;
    logic                  lsu_we_o;
    logic [2:0]            lsu_dtype_o;
    logic [DATA_WIDTH-1:0] lsu_data_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic [4:0]            rsp_rd_o;
    logic                  rsp_is_load_o;
    logic                  rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_dtype_i, req_rd_i,
        output lsu_data_i, rsp_ready_i,
        input  req_ready_o, lsu_addr_o, lsu_data_o, lsu_we_o, lsu_dtype_o,
        input  rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_is_load_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_dtype_i, req_rd_i,
        input  lsu_data_i, rsp_ready_i,
        output req_ready_o, lsu_addr_o, lsu_data_o, lsu_we_o, lsu_dtype_o,
        output rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_is_load_o, rsp_err_o
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- memory stage controller, one access in flight.
//
// Accepts a load/store request in IDLE, checks type/alignment, drives the
// LSU for one ISSUE cycle (stores strobe lsu_we_o there), waits RD_LATENCY
// cycles for load data, then presents a held response until rsp_ready_i.
// Bad requests skip the LSU and respond immediately with rsp_err_o=1.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : mem_stage_ctrl_if.slave (req_*, lsu_*, rsp_* groups)
// Parameters: DATA_WIDTH, ADDR_WIDTH, RD_LATENCY (1..4).
module mem_stage_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_stage_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // WAIT counts down from RD_LATENCY-1 to 0, giving RD_LATENCY WAIT cycles.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

    // Returns 1 for illegal type codes and misaligned halfword/word addresses.
    function automatic logic access_err(input logic [2:0] dtype, input logic [1:0] addr_lo);
        logic err;
        case (dtype)
            3'b000, 3'b011: err = 1'b0;
            3'b001, 3'b100: err = addr_lo[0];
            3'b010:         err = (addr_lo != 2'b00);
            default:        err = 1'b1;
        endcase
        return err;
    endfunction

    state_t                state_r, state_s;
    logic [1:0]            wait_cnt_r, wait_cnt_s;
    logic                  req_ready_r, req_ready_s;
    logic [ADDR_WIDTH-1:0] lsu_addr_r, lsu_addr_s;
    logic [DATA_WIDTH-1:0] lsu_data_r, lsu_data_s;
    logic [2:0]            lsu_dtype_r, lsu_dtype_s;
    logic                  lsu_we_r, lsu_we_s;
    logic                  rsp_valid_r, rsp_valid_s;
    logic [DATA_WIDTH-1:0] rsp_data_r, rsp_data_s;
    logic [4:0]            rsp_rd_r, rsp_rd_s;
    logic                  rsp_is_load_r, rsp_is_load_s;
    logic                  rsp_err_r, rsp_err_s;
    logic                  req_err_s;

    assign req_err_s = access_err(bus.req_dtype_i, bus.req_addr_i[1:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    if (req_err_s) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rsp_is_load_r) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless updated.
    always_comb begin
        wait_cnt_s    = wait_cnt_r;
        lsu_addr_s    = lsu_addr_r;
        lsu_data_s    = lsu_data_r;
        lsu_dtype_s   = lsu_dtype_r;
        rsp_data_s    = rsp_data_r;
        rsp_rd_s      = rsp_rd_r;
        rsp_is_load_s = rsp_is_load_r;
        rsp_err_s     = rsp_err_r;
        lsu_we_s      = 1'b0;
        req_ready_s   = (state_s == ST_IDLE);
        rsp_valid_s   = (state_s == ST_RESP);
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    lsu_addr_s    = bus.req_addr_i;
                    lsu_data_s    = bus.req_wdata_i;
                    lsu_dtype_s   = bus.req_dtype_i;
                    rsp_rd_s      = bus.req_rd_i;
                    rsp_is_load_s = ~bus.req_we_i;
                    rsp_err_s     = req_err_s;
                    rsp_data_s    = '0;
                    wait_cnt_s    = WAIT_INIT;
                    // The write strobe lives only in the ISSUE cycle of a legal store.
                    lsu_we_s      = bus.req_we_i & ~req_err_s;
                end else begin
                    lsu_we_s      = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    rsp_data_s = bus.lsu_data_i;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end
            default: begin
                lsu_we_s = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r    <= 2'd0;
            req_ready_r   <= 1'b1;
            lsu_addr_r    <= '0;
            lsu_data_r    <= '0;
            lsu_dtype_r   <= 3'b000;
            lsu_we_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= '0;
            rsp_rd_r      <= 5'd0;
            rsp_is_load_r <= 1'b0;
            rsp_err_r     <= 1'b0;
        end else begin
            wait_cnt_r    <= wait_cnt_s;
            req_ready_r   <= req_ready_s;
            lsu_addr_r    <= lsu_addr_s;
            lsu_data_r    <= lsu_data_s;
            lsu_dtype_r   <= lsu_dtype_s;
            lsu_we_r      <= lsu_we_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_data_r    <= rsp_data_s;
            rsp_rd_r      <= rsp_rd_s;
            rsp_is_load_r <= rsp_is_load_s;
            rsp_err_r     <= rsp_err_s;
        end
    end

    assign bus.req_ready_o   = req_ready_r;
    assign bus.lsu_addr_o    = lsu_addr_r;
    assign bus.lsu_data_o    = lsu_data_r;
    assign bus.lsu_dtype_o   = lsu_dtype_r;
    // Reset kills a pending store strobe in the very cycle it is raised.
    assign bus.lsu_we_o      = lsu_we_r & ~reset;
    assign bus.rsp_valid_o   = rsp_valid_r;
    assign bus.rsp_data_o    = rsp_data_r;
    assign bus.rsp_rd_o      = rsp_rd_r;
    assign bus.rsp_is_load_o = rsp_is_load_r;
    assign bus.rsp_err_o     = rsp_err_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl -- self-checking bench for mem_stage_ctrl.
// Directed cases (store, signed byte load, misaligned/illegal, backpressure,
// reset mid-access, back-to-back) followed by randomized transactions, all
// compared against an access-level reference model of latency and response.
module tb_mem_stage_ctrl;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int RD = 1;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mem_stage_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_stage_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: which requests are rejected.
    function automatic bit model_err(input logic [2:0] dtype, input logic [11:0] addr);
        int size;
        if (dtype > 3'd4) return 1'b1;
        size = (dtype == 3'd2) ? 4 : ((dtype == 3'd1 || dtype == 3'd4) ? 2 : 1);
        return (int'(addr) % size) != 0;
    endfunction

    task automatic drive_garbage();
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'($urandom);
        bus.req_addr_i  = 12'($urandom);
        bus.req_wdata_i = $urandom;
        bus.req_dtype_i = 3'($urandom);
        bus.req_rd_i    = 5'($urandom);
    endtask

    // One complete transaction, entered and left at a negedge with the DUT idle.
    task automatic run_txn(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [2:0] dtype, input logic [4:0] rd,
                           input logic [31:0] ldata, input int stall);
        bit          err;
        int          exp_lat;
        logic [31:0] exp_data;
        int          we_cnt;
        int          we_cyc;
        int          got_lat;
        err      = model_err(dtype, addr);
        exp_lat  = err ? 1 : (we ? 2 : 2 + RD);
        exp_data = (err || we) ? 32'h0 : ldata;
        we_cnt   = 0;
        we_cyc   = 0;
        got_lat  = 0;

        chk("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        bus.req_dtype_i = dtype;
        bus.req_rd_i    = rd;
        bus.lsu_data_i  = $urandom;
        bus.rsp_ready_i = 1'b0;

        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.lsu_we_o) begin
                we_cnt++;
                we_cyc = c;
            end
            if (bus.rsp_valid_o) begin
                got_lat = c;
                break;
            end
            chk("req_ready_busy", 32'(bus.req_ready_o), 32'd0);
            if (!err) begin
                chk("lsu_addr_hold", 32'(bus.lsu_addr_o), 32'(addr));
                chk("lsu_dtype_hold", 32'(bus.lsu_dtype_o), 32'(dtype));
                if (we) chk("lsu_wdata", bus.lsu_data_o, wdata);
            end
            // Foreign request while busy must be ignored.
            drive_garbage();
            // Load data is valid only just before the capturing edge.
            bus.lsu_data_i = (c == exp_lat - 1) ? ldata : $urandom;
        end

        chk("rsp_latency", 32'(got_lat), 32'(exp_lat));
        if (got_lat == 0) begin
            bus.req_valid_i = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        chk("lsu_we_count", 32'(we_cnt), (!err && we) ? 32'd1 : 32'd0);
        if (!err && we) chk("lsu_we_cycle", 32'(we_cyc), 32'd1);
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(err));
        chk("rsp_data", bus.rsp_data_o, exp_data);
        chk("rsp_rd", 32'(bus.rsp_rd_o), 32'(rd));
        if (!err) chk("rsp_is_load", 32'(bus.rsp_is_load_o), 32'(!we));

        for (int s = 0; s < stall; s++) begin
            drive_garbage();
            @(negedge clk);
            chk("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
            chk("stall_data", bus.rsp_data_o, exp_data);
            chk("stall_err", 32'(bus.rsp_err_o), 32'(err));
            chk("stall_rd", 32'(bus.rsp_rd_o), 32'(rd));
            chk("stall_ready", 32'(bus.req_ready_o), 32'd0);
            chk("stall_we", 32'(bus.lsu_we_o), 32'd0);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("post_hs_ready", 32'(bus.req_ready_o), 32'd1);
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
        chk({tag, "_rsp_is_load"}, 32'(bus.rsp_is_load_o), 32'd0);
        chk({tag, "_lsu_we"}, 32'(bus.lsu_we_o), 32'd0);
        chk({tag, "_rsp_data"}, bus.rsp_data_o, 32'd0);
        chk({tag, "_rsp_rd"}, 32'(bus.rsp_rd_o), 32'd0);
        chk({tag, "_lsu_addr"}, 32'(bus.lsu_addr_o), 32'd0);
        chk({tag, "_lsu_data"}, bus.lsu_data_o, 32'd0);
        chk({tag, "_lsu_dtype"}, 32'(bus.lsu_dtype_o), 32'd0);
    endtask

    initial begin
        logic        r_we;
        logic [11:0] r_addr;
        logic [2:0]  r_dtype;
        vectors     = 0;
        miscompares = 0;
        reset           = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 12'h000;
        bus.req_wdata_i = 32'h0;
        bus.req_dtype_i = 3'b000;
        bus.req_rd_i    = 5'd0;
        bus.lsu_data_i  = 32'h0;
        bus.rsp_ready_i = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Word store.
        run_txn(1'b1, 12'h010, 32'hDEADBEEF, 3'b010, 5'd3, 32'h0, 0);
        // Signed byte load, data already extended by the LSU.
        run_txn(1'b0, 12'h013, 32'h0, 3'b000, 5'd17, 32'hFFFFFF80, 0);
        // Misaligned word, misaligned halfword, illegal type.
        run_txn(1'b1, 12'h002, 32'h12345678, 3'b010, 5'd1, 32'h0, 0);
        run_txn(1'b0, 12'h005, 32'h0, 3'b001, 5'd2, 32'h0, 0);
        run_txn(1'b0, 12'h008, 32'h0, 3'b110, 5'd4, 32'h0, 0);
        // Backpressure on a load response.
        run_txn(1'b0, 12'h104, 32'h0, 3'b010, 5'd9, 32'hA5A5_5A5A, 5);
        // Back-to-back store then load at the same address.
        run_txn(1'b1, 12'hEF0, 32'hCAFE_F00D, 3'b010, 5'd5, 32'h0, 0);
        run_txn(1'b0, 12'hEF0, 32'h0, 3'b010, 5'd6, 32'hCAFE_F00D, 0);

        // Reset during the ISSUE cycle of a store.
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 12'h020;
        bus.req_wdata_i = 32'h1111_2222;
        bus.req_dtype_i = 3'b010;
        bus.req_rd_i    = 5'd8;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("issue_we_before_reset", 32'(bus.lsu_we_o), 32'd1);
        reset = 1'b1;
        #1;
        chk("issue_we_during_reset", 32'(bus.lsu_we_o), 32'd0);
        @(negedge clk);
        chk_reset_vals("midreset");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("after_reset_ready", 32'(bus.req_ready_o), 32'd1);
            chk("after_reset_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        end

        // Reset while a response is pending.
        bus.req_valid_i = 1'b1;
        bus.req_dtype_i = 3'b111;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("resp_before_reset", 32'(bus.rsp_valid_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("resp_reset_ready", 32'(bus.req_ready_o), 32'd1);
        chk("resp_reset_no_rsp", 32'(bus.rsp_valid_o), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r_we    = 1'($urandom);
            r_addr  = 12'($urandom);
            r_dtype = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            run_txn(r_we, r_addr, $urandom, r_dtype, 5'($urandom), $urandom,
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data path width.
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set the byte address width (4096-byte space).
REQ-003 Parameter RD_LATENCY, default 1, range 1-4, SHALL set the number of clock edges from address presentation to valid lsu_data_i.
REQ-004 Port clk, input, 1 bit, SHALL be the single rising-edge clock.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-006 Ports req_valid_i (in, 1) and req_ready_o (out, 1) SHALL form the upstream request handshake.
REQ-007 Ports req_we_i (in, 1), req_addr_i (in, ADDR_WIDTH), req_wdata_i (in, DATA_WIDTH), req_dtype_i (in, 3) and req_rd_i (in, 5) SHALL carry store flag, byte address, store data, access type and destination register tag.
REQ-008 Ports lsu_addr_o (out, ADDR_WIDTH), lsu_data_o (out, DATA_WIDTH), lsu_we_o (out, 1) and lsu_dtype_o (out, 3) SHALL drive the downstream load/store unit.
REQ-009 Port lsu_data_i, input, DATA_WIDTH, SHALL carry the extended load data returned by the load/store unit.
REQ-010 Ports rsp_valid_o (out, 1) and rsp_ready_i (in, 1) SHALL form the writeback response handshake.
REQ-011 Ports rsp_data_o (out, DATA_WIDTH), rsp_rd_o (out, 5), rsp_is_load_o (out, 1) and rsp_err_o (out, 1) SHALL carry load result, tag, load flag and misalignment/illegal-type error.

Function
REQ-012 Access type codes SHALL be: 000 byte, 001 halfword, 010 word, 011 byte unsigned, 100 halfword unsigned; codes 101-111 SHALL be illegal.
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-014 req_ready_o SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid_i and req_ready_o are both 1, and all request fields SHALL be registered at that edge.
REQ-015 Misaligned SHALL mean: halfword types with addr[0]=1, or word type with addr[1:0]!=00.
REQ-016 An accepted misaligned or illegal-type request SHALL go IDLE->RESP with rsp_err_o=1 and rsp_data_o=0, and SHALL NOT assert lsu_we_o.
REQ-017 An accepted legal request SHALL go IDLE->ISSUE; lsu_addr_o, lsu_data_o and lsu_dtype_o SHALL be held stable from ISSUE through the last WAIT cycle.
REQ-018 For a store, lsu_we_o SHALL be 1 for exactly the single ISSUE cycle, and the FSM SHALL go ISSUE->RESP with rsp_err_o=0, rsp_is_load_o=0 and rsp_data_o=0.
REQ-019 For a load, lsu_we_o SHALL stay 0; the FSM SHALL go ISSUE->WAIT, stay in WAIT for RD_LATENCY cycles, and capture lsu_data_i into rsp_data_o on the edge that leaves the last WAIT cycle.
REQ-020 Latency from the acceptance edge to rsp_valid_o=1 SHALL be: error 1 cycle, store 2 cycles, load 2+RD_LATENCY cycles.
REQ-021 In RESP, rsp_valid_o SHALL be 1 and all rsp_* outputs SHALL be held stable until rsp_ready_i=1; the FSM SHALL then return to IDLE on that edge.
REQ-022 req_valid_i SHALL be ignored outside IDLE; the throughput limit is one request in flight.
REQ-023 lsu_we_o SHALL be 0 in IDLE, WAIT and RESP, and in any cycle where reset=1.
REQ-024 Address wrap SHALL NOT occur; the block SHALL pass addresses unmodified.

Reset
REQ-025 On any edge with reset=1, the FSM SHALL enter IDLE, and rsp_valid_o, rsp_err_o, rsp_is_load_o, lsu_we_o SHALL be 0; rsp_data_o, rsp_rd_o, lsu_addr_o, lsu_data_o SHALL be 0; lsu_dtype_o SHALL be 000.
REQ-026 Reset asserted mid-operation (ISSUE, WAIT or RESP) SHALL abort the access with no response, and req_ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-027 Word store: addr 0x010, data 0xDEADBEEF, dtype 010 -> lsu_we_o high for one cycle with lsu_addr_o=0x010; rsp_valid_o 2 cycles after acceptance, err=0, is_load=0.
REQ-028 Load byte signed: addr 0x013, lsu_data_i=0xFFFFFF80, RD_LATENCY=1 -> rsp_valid_o 3 cycles after acceptance, rsp_data_o=0xFFFFFF80, rsp_rd_o equals the request tag, is_load=1.
REQ-029 Misaligned: word at 0x002, halfword at 0x005, and dtype 110 -> each gives rsp_err_o=1 one cycle after acceptance, with lsu_we_o never asserted.
REQ-030 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_* stable, req_ready_o=0 throughout, and a new req_valid_i is not accepted until the cycle after the rsp handshake.
REQ-031 Reset mid-store: assert reset in the ISSUE cycle of a store -> lsu_we_o=0 in that cycle, no rsp_valid_o, and IDLE with req_ready_o=1 after reset.
REQ-032 Back-to-back: GPIO store 0xEF0 then load 0xEF0 with rsp_ready_i=1 -> exactly two responses in order, the second accepted in the cycle after the first handshake.
